maf_res_buf: RTL and testbench

- Writeback buffer directly downstream of the multiply-add unit (maf).
- maf has a fixed latency and cannot be stalled, so this block tracks in-flight operations and tells the issuer when issuing is safe.
- It captures every res/res_rdy result in a FIFO and presents the results to the consumer with a valid/ready handshake.
- Issue is guaranteed never to overflow the buffer.

---
 rtl/maf_pkg.sv | 7 +
 rtl/maf_res_fifo.sv | 70 +++++++
 rtl/maf_res_buf.sv | 126 ++++++++++++
 tb/tb_maf_res_buf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/maf_pkg.sv
// Shared constants for the maf datapath and its writeback buffer.
package maf_pkg;
  localparam int unsigned MAF_LAT = 4;
  localparam int unsigned FP_W    = 32;
  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;
endpackage

// File: rtl/maf_res_fifo.sv
// First-word-fall-through FIFO holding maf results; count separates full from empty.
module maf_res_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     push_drop
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, pop_en, push_en;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    pop_en    = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_en   = push_req & (~full | pop_en);
    push_drop = push_req & ~push_en;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/maf_res_buf.sv
// Writeback buffer after the maf unit: in-flight tracking, post-reset drain, result FIFO.
// Optional result tagging is enabled by defining MAF_RES_BUF_TAG_EN.
module maf_res_buf
  import maf_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAF_LAT = maf_pkg::MAF_LAT,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_vld,
`ifdef MAF_RES_BUF_TAG_EN
  input  logic [TAG_W-1:0]       op_tag,
  output logic [TAG_W-1:0]       out_tag,
`endif
  output logic                   issue_ok,
  input  logic [31:0]            res,
  input  logic                   res_rdy,
  output logic                   out_vld,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] in_flight,
  output logic [1:0]             err
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = $clog2(MAF_LAT + 1);
`ifdef MAF_RES_BUF_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int unsigned ENT_W = FP_W + (TAG_EN ? TAG_W : 0);

  logic [DW-1:0]    drain_q, drain_d;
  logic [CW-1:0]    in_flight_q, in_flight_d;
  logic [1:0]       err_q, err_d;
  logic             drain_done, res_acc, fifo_empty, push_drop;
  logic [CW:0]      occupancy;
  logic [ENT_W-1:0] fifo_wdata, fifo_rdata;

  always_comb begin
    drain_done = (drain_q == '0);
    res_acc    = res_rdy & drain_done;
    occupancy  = {1'b0, count} + {1'b0, in_flight_q};
    issue_ok   = drain_done & (occupancy < (CW+1)'(DEPTH));

    drain_d = drain_done ? drain_q : drain_q - DW'(1);

    // Every op_vld is counted, even one issued against issue_ok.
    in_flight_d = in_flight_q;
    case ({op_vld, res_acc && (in_flight_q != '0)})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase

    err_d = err_q;
    if (push_drop) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (res_acc && (in_flight_q == '0)) begin
      err_d[ERR_UNF] = 1'b1;
    end
  end

`ifdef MAF_RES_BUF_TAG_EN
  logic [TAG_W-1:0] tag_sr_q [MAF_LAT];
  logic [TAG_W-1:0] tag_sr_d [MAF_LAT];

  always_comb begin
    tag_sr_d[0] = op_tag;
    for (int unsigned i = 1; i < MAF_LAT; i++) begin
      tag_sr_d[i] = tag_sr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAF_LAT; i++) begin
        tag_sr_q[i] <= '0;
      end
    end else begin
      tag_sr_q <= tag_sr_d;
    end
  end

  assign fifo_wdata = {tag_sr_q[MAF_LAT-1], res};
  assign out_tag    = fifo_rdata[ENT_W-1:FP_W];
`else
  assign fifo_wdata = res;
`endif

  maf_res_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (res_acc),
    .pop_req   (out_ready),
    .wdata     (fifo_wdata),
    .rdata     (fifo_rdata),
    .count     (count),
    .empty     (fifo_empty),
    .push_drop (push_drop)
  );

  assign out_vld   = ~fifo_empty;
  assign out_data  = fifo_rdata[FP_W-1:0];
  assign in_flight = in_flight_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q     <= DW'(MAF_LAT);
      in_flight_q <= '0;
      err_q       <= '0;
    end else begin
      drain_q     <= drain_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_maf_res_buf.sv
// Directed vector bench for maf_res_buf (DEPTH=8, MAF_LAT=4).
module tb_maf_res_buf;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_vld = 1'b0;
  logic          issue_ok;
  logic [31:0]   res = '0;
  logic          res_rdy = 1'b0;
  logic          out_vld;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [CW-1:0] count;
  logic [CW-1:0] in_flight;
  logic [1:0]    err;
`ifdef MAF_RES_BUF_TAG_EN
  logic [3:0]    op_tag = '0;
  logic [3:0]    out_tag;
`endif

  maf_res_buf #(
    .DEPTH   (DEPTH),
    .MAF_LAT (4),
    .TAG_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .op_vld    (op_vld),
`ifdef MAF_RES_BUF_TAG_EN
    .op_tag    (op_tag),
    .out_tag   (out_tag),
`endif
    .issue_ok  (issue_ok),
    .res       (res),
    .res_rdy   (res_rdy),
    .out_vld   (out_vld),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .in_flight (in_flight),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        op;
    logic        rr;
    logic [31:0] res;
    logic        ordy;
    logic        e_ok;
    logic        e_vld;
    logic        chk_data;
    logic [31:0] e_data;
    int          e_cnt;
    int          e_if;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic op, input logic rr, input logic [31:0] rs,
                      input logic ordy, input logic ok, input logic vld, input logic cd,
                      input logic [31:0] d, input int cnt, input int inf, input logic [1:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.rr = rr; v.res = rs; v.ordy = ordy;
    v.e_ok = ok; v.e_vld = vld; v.chk_data = cd; v.e_data = d;
    v.e_cnt = cnt; v.e_if = inf; v.e_err = e;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] dv(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  initial begin
    int first;
    // Reset, then drain window with an ignored stale res_rdy
    addv(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'b00);
    addv(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'b00);
    addv(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'b00);
    addv(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    addv(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'b00);
    // Single op
    addv(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) addv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00);
    addv(0, 0, 1, 32'h3F80_0000, 0, 1, 0, 0, 0, 0, 1, 2'b00);
    addv(0, 0, 0, 0, 1,  1, 1, 1, 32'h3F80_0000, 1, 0, 2'b00);
    // Back-to-back issue into a stalled consumer
    for (int i = 0; i < 4; i++) addv(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, i, 2'b00);
    for (int i = 0; i < 4; i++) addv(0, 1, 1, dv(i), 0, 1, i > 0, i > 0, dv(0), i, 4, 2'b00);
    for (int i = 4; i < 8; i++) addv(0, 0, 1, dv(i), 0, 0, 1, 1, dv(0), i, 8 - i, 2'b00);
    // Full: push+pop together, then a forced drop
    addv(0, 0, 1, dv(8), 1, 0, 1, 1, dv(0), 8, 0, 2'b00);
    addv(0, 0, 1, dv(9), 0, 0, 1, 1, dv(1), 8, 0, 2'b10);
    addv(0, 0, 0, 0, 1,  0, 1, 1, dv(1), 8, 0, 2'b11);
    for (int k = 2; k <= 8; k++) addv(0, 0, 0, 0, 1, 1, 1, 1, dv(k), 9 - k, 0, 2'b11);
    // Mid-stream reset with count, in_flight and err all non-zero
    addv(0, 1, 1, 32'h55, 0, 1, 0, 0, 0, 0, 0, 2'b11);
    addv(0, 0, 0, 0, 0,  1, 1, 1, 32'h55, 1, 1, 2'b11);
    addv(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) addv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    // res_rdy with nothing outstanding: flagged but stored
    addv(0, 0, 1, 32'h1234_5678, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    addv(0, 0, 0, 0, 1,  1, 1, 1, 32'h1234_5678, 1, 0, 2'b10);
    addv(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2'b10);

    repeat (2) @(posedge clk);
    foreach (vq[n]) begin
      @(negedge clk);
      rst = vq[n].rst; op_vld = vq[n].op; res_rdy = vq[n].rr;
      res = vq[n].res; out_ready = vq[n].ordy;
      #1;
      chk($sformatf("issue_ok[%0d]", n), 32'(issue_ok), 32'(vq[n].e_ok));
      chk($sformatf("out_vld[%0d]", n), 32'(out_vld), 32'(vq[n].e_vld));
      chk($sformatf("count[%0d]", n), 32'(count), 32'(vq[n].e_cnt));
      chk($sformatf("in_flight[%0d]", n), 32'(in_flight), 32'(vq[n].e_if));
      chk($sformatf("err[%0d]", n), 32'(err), 32'(vq[n].e_err));
      if (vq[n].chk_data) chk($sformatf("out_data[%0d]", n), out_data, vq[n].e_data);
    end

    // Minimum op_vld -> out_vld latency is MAF_LAT+1 cycles
    first = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      op_vld = (cyc == 0); res_rdy = (cyc == 4); res = 32'hC0DE_0001; out_ready = 1'b0;
      #1;
      if (cyc == 1) chk("lat_in_flight1", 32'(in_flight), 32'd1);
      if (cyc == 5) chk("lat_in_flight0", 32'(in_flight), 32'd0);
      if (out_vld && first < 0) begin
        first = cyc;
        chk("lat_data", out_data, 32'hC0DE_0001);
      end
    end
    chk("lat_cycles", 32'(first), 32'd5);
    @(negedge clk); op_vld = 0; res_rdy = 0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; #1;
    chk("lat_popped", 32'(count), 32'd0);

`ifdef MAF_RES_BUF_TAG_EN
    // Tags 3,7,1 on consecutive issues follow their results
    begin
      logic [3:0] tags [3];
      tags[0] = 4'd3; tags[1] = 4'd7; tags[2] = 4'd1;
      for (int cyc = 0; cyc < 9; cyc++) begin
        @(negedge clk);
        op_vld  = (cyc < 3);
        op_tag  = (cyc < 3) ? tags[cyc] : 4'd0;
        res_rdy = (cyc >= 4 && cyc < 7);
        res     = 32'hB000_0000 + 32'(cyc - 4);
        out_ready = (cyc >= 5);
        #1;
        if (cyc >= 5 && cyc < 8) begin
          chk($sformatf("tag_vld[%0d]", cyc), 32'(out_vld), 32'd1);
          chk($sformatf("tag_data[%0d]", cyc), out_data, 32'hB000_0000 + 32'(cyc - 5));
          chk($sformatf("tag_val[%0d]", cyc), 32'(out_tag), 32'(tags[cyc-5]));
        end
      end
      op_vld = 0; res_rdy = 0; out_ready = 0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
